// File: rtl/font_rom_arbiter_if.sv
// font_rom_arbiter_if: renderer, secondary requester, statistics and font ROM signals of the arbiter
interface font_rom_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int FONT_W = 8,
  parameter int CNT_W  = 16
);
  logic              ren_valid;
  logic [ADDR_W-1:0] ren_addr;
  logic [FONT_W-1:0] ren_q;
  logic              sec_req;
  logic [ADDR_W-1:0] sec_addr;
  logic              sec_ack;
  logic              sec_rvalid;
  logic [FONT_W-1:0] sec_rdata;
  logic              blanking;
  logic              conflict_clr;
  logic [CNT_W-1:0]  conflict_cnt;
  logic [ADDR_W-1:0] rom_addr;
  logic [FONT_W-1:0] rom_q;
  modport master (
    output ren_valid, ren_addr, sec_req, sec_addr, blanking, conflict_clr, rom_q,
    input  ren_q, sec_ack, sec_rvalid, sec_rdata, conflict_cnt, rom_addr
  );
  modport slave (
    input  ren_valid, ren_addr, sec_req, sec_addr, blanking, conflict_clr, rom_q,
    output ren_q, sec_ack, sec_rvalid, sec_rdata, conflict_cnt, rom_addr
  );
endinterface

// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares the font ROM between the renderer (never stalled) and one req/ack secondary; FONT_ARB_BLANK_ONLY_EN limits secondary grants to blanking
module font_rom_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int FONT_W  = 8,
  parameter int ROM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              rst,
  font_rom_arbiter_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t            state_q, state_d;
  logic [2:0]        lat_q, lat_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              sec_ack_q, sec_ack_d;
  logic              sec_rvalid_q, sec_rvalid_d;
  logic [FONT_W-1:0] sec_rdata_q, sec_rdata_d;
  logic [CNT_W-1:0]  conflict_q, conflict_d;
  logic              grant_ok;
  logic              sec_go;
  logic              blocked;
`ifdef FONT_ARB_BLANK_ONLY_EN
  assign grant_ok = bus.blanking;
`else
  logic unused_blanking;
  assign unused_blanking = bus.blanking;
  assign grant_ok = 1'b1;
`endif
  assign sec_go  = (state_q == IDLE) && bus.sec_req && !bus.ren_valid && grant_ok;
  assign blocked = (state_q == IDLE) && bus.sec_req && bus.ren_valid;
  // next state: renderer owns the address port, secondary takes leftover cycles, data captured once the ROM pipe drains
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    sec_ack_d    = 1'b0;
    sec_rvalid_d = 1'b0;
    sec_rdata_d  = sec_rdata_q;
    rom_addr_d   = bus.ren_valid ? bus.ren_addr : sec_go ? bus.sec_addr : rom_addr_q;
    conflict_d   = bus.conflict_clr ? '0 : (blocked && !(&conflict_q)) ? conflict_q + 1'b1 : conflict_q;
    if (state_q == IDLE) begin
      if (sec_go) begin
        state_d   = WAIT;
        sec_ack_d = 1'b1;
        lat_d     = 3'(ROM_LAT);
      end
    end else if (lat_q == 3'd0) begin
      state_d      = IDLE;
      sec_rvalid_d = 1'b1;
      sec_rdata_d  = bus.rom_q;
    end else begin
      lat_d = lat_q - 3'd1;
    end
  end
  // state register; reset discards any in-flight secondary read
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      rom_addr_q   <= '0;
      sec_ack_q    <= 1'b0;
      sec_rvalid_q <= 1'b0;
      sec_rdata_q  <= '0;
      conflict_q   <= '0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      rom_addr_q   <= rom_addr_d;
      sec_ack_q    <= sec_ack_d;
      sec_rvalid_q <= sec_rvalid_d;
      sec_rdata_q  <= sec_rdata_d;
      conflict_q   <= conflict_d;
    end
  end
  assign bus.ren_q        = bus.rom_q;
  assign bus.rom_addr     = rom_addr_q;
  assign bus.sec_ack      = sec_ack_q;
  assign bus.sec_rvalid   = sec_rvalid_q;
  assign bus.sec_rdata    = sec_rdata_q;
  assign bus.conflict_cnt = conflict_q;
endmodule
